// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter.
//   - arbiter FSM state encoding
//   - requester identifiers
//   - default parameter values (data width, address width, lock limit)
package reg_bank_arbiter_pkg;

    localparam int DW_W_DEF     = 8;
    localparam int AW_DEF       = 3;
    localparam int LOCK_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/reg_bank_arbiter_arb.sv
// rr_lock_arbiter: two-requester round-robin arbiter with a bounded lock.
// Ports:
//   Clk, Rst          clock, asynchronous active-high reset
//   req_a, req_b      requests
//   lock_a, lock_b    keep ownership after the current grant
//   gnt_a, gnt_b      combinational grants (never both high)
module rr_lock_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_a,
    input  logic lock_b,
    output logic gnt_a,
    output logic gnt_b
);

    localparam logic [3:0] LMAX = 4'(LOCK_MAX);

    arb_state_e state_q, state_d;
    req_id_e    prio_q, prio_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;

    logic       granted;
    req_id_e    win, other;
    logic       win_lock, other_req;
    logic [3:0] cnt_inc;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;

        unique case (state_q)
            OWN_A: begin
                granted = req_a;
                win     = REQ_A;
            end
            OWN_B: begin
                granted = req_b;
                win     = REQ_B;
            end
            default: begin
                granted = req_a | req_b;
                if (req_a && req_b) win = prio_q;
                else if (req_b)     win = REQ_B;
                else                win = REQ_A;
            end
        endcase

        other     = (win == REQ_A) ? REQ_B : REQ_A;
        win_lock  = (win == REQ_A) ? lock_a : lock_b;
        other_req = (win == REQ_A) ? req_b : req_a;

        // First locked grant starts the count at 1; later ones saturate.
        if (state_q == IDLE)        cnt_inc = 4'd1;
        else if (lock_cnt_q >= LMAX) cnt_inc = LMAX;
        else                        cnt_inc = lock_cnt_q + 4'd1;

        if (!granted) begin
            // Owner dropped its request: idle release, no grant this cycle.
            if (state_q != IDLE) begin
                state_d    = IDLE;
                prio_d     = (state_q == OWN_A) ? REQ_B : REQ_A;
                lock_cnt_d = 4'd0;
            end
        end else if (!win_lock || (cnt_inc == LMAX && other_req)) begin
            // Unlocked grant, or lock exhausted with the other side waiting.
            state_d    = IDLE;
            prio_d     = other;
            lock_cnt_d = 4'd0;
        end else begin
            state_d    = (win == REQ_A) ? OWN_A : OWN_B;
            lock_cnt_d = cnt_inc;
        end

        // Reset kills the grant immediately so no bank write can slip through.
        gnt_a = granted && (win == REQ_A) && !Rst;
        gnt_b = granted && (win == REQ_B) && !Rst;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            prio_q     <= REQ_A;
            lock_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares a single-write-port register bank between two
// requesters (A: datapath/sequencer, B: loader/debug).
// Ports:
//   Clk, Rst                     clock, asynchronous active-high reset
//   ReqX/WrX/LockX/SelX/DatX     requester X transaction (X = A, B)
//   GntX                         X's transaction executes this cycle
//   VldX/RxX/RyX                 registered read return, one cycle after grant
//   SelR/RW/DW                   bank address pair, write enable, write data
//   BRx/BRy                      bank combinational read data
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int DW_W     = DW_W_DEF,
    parameter int AW       = AW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            ReqA,
    input  logic            WrA,
    input  logic            LockA,
    input  logic [2*AW-1:0] SelA,
    input  logic [DW_W-1:0] DatA,
    output logic            GntA,
    output logic            VldA,
    output logic [DW_W-1:0] RxA,
    output logic [DW_W-1:0] RyA,
    input  logic            ReqB,
    input  logic            WrB,
    input  logic            LockB,
    input  logic [2*AW-1:0] SelB,
    input  logic [DW_W-1:0] DatB,
    output logic            GntB,
    output logic            VldB,
    output logic [DW_W-1:0] RxB,
    output logic [DW_W-1:0] RyB,
    output logic [2*AW-1:0] SelR,
    output logic            RW,
    output logic [DW_W-1:0] DW,
    input  logic [DW_W-1:0] BRx,
    input  logic [DW_W-1:0] BRy
);

    logic            vld_a_q, vld_a_d, vld_b_q, vld_b_d;
    logic [DW_W-1:0] rx_a_q, rx_a_d, ry_a_q, ry_a_d;
    logic [DW_W-1:0] rx_b_q, rx_b_d, ry_b_q, ry_b_d;

    rr_lock_arbiter #(.LOCK_MAX(LOCK_MAX)) u_arb (
        .Clk    (Clk),
        .Rst    (Rst),
        .req_a  (ReqA),
        .req_b  (ReqB),
        .lock_a (LockA),
        .lock_b (LockB),
        .gnt_a  (GntA),
        .gnt_b  (GntB)
    );

    // Bank mux: idle bank cycles present address/data 0 with RW low.
    always_comb begin
        SelR = '0;
        DW   = '0;
        RW   = 1'b0;
        if (GntA) begin
            SelR = SelA;
            DW   = DatA;
            RW   = WrA;
        end else if (GntB) begin
            SelR = SelB;
            DW   = DatB;
            RW   = WrB;
        end
    end

    // Read return: capture bank data on a granted read, hold otherwise.
    always_comb begin
        vld_a_d = GntA && !WrA;
        vld_b_d = GntB && !WrB;
        rx_a_d  = vld_a_d ? BRx : rx_a_q;
        ry_a_d  = vld_a_d ? BRy : ry_a_q;
        rx_b_d  = vld_b_d ? BRx : rx_b_q;
        ry_b_d  = vld_b_d ? BRy : ry_b_q;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            rx_a_q  <= '0;
            ry_a_q  <= '0;
            rx_b_q  <= '0;
            ry_b_q  <= '0;
        end else begin
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
            rx_a_q  <= rx_a_d;
            ry_a_q  <= ry_a_d;
            rx_b_q  <= rx_b_d;
            ry_b_q  <= ry_b_d;
        end
    end

    assign VldA = vld_a_q;
    assign VldB = vld_b_q;
    assign RxA  = rx_a_q;
    assign RyA  = ry_a_q;
    assign RxB  = rx_b_q;
    assign RyB  = ry_b_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed vector table, random traffic against
// a behavioural model, and a reset-during-lock sequence.
module tb_reg_bank_arbiter;

    localparam int LOCK_MAX = 4;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       ReqA, WrA, LockA, ReqB, WrB, LockB;
    logic [5:0] SelA, SelB, SelR;
    logic [7:0] DatA, DatB, DW, BRx, BRy, RxA, RyA, RxB, RyB;
    logic       GntA, GntB, VldA, VldB, RW;

    logic [7:0] bank [8] = '{default: 8'h00};

    reg_bank_arbiter #(.DW_W(8), .AW(3), .LOCK_MAX(LOCK_MAX)) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqA(ReqA), .WrA(WrA), .LockA(LockA), .SelA(SelA), .DatA(DatA),
        .GntA(GntA), .VldA(VldA), .RxA(RxA), .RyA(RyA),
        .ReqB(ReqB), .WrB(WrB), .LockB(LockB), .SelB(SelB), .DatB(DatB),
        .GntB(GntB), .VldB(VldB), .RxB(RxB), .RyB(RyB),
        .SelR(SelR), .RW(RW), .DW(DW), .BRx(BRx), .BRy(BRy)
    );

    always #5 Clk = ~Clk;

    // Register bank environment: combinational read, write on the edge.
    always @(posedge Clk) if (RW) bank[SelR[2:0]] <= DW;
    assign BRx = bank[SelR[2:0]];
    assign BRy = bank[SelR[5:3]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner 0=none 1=A 2=B, prio 0=A 1=B.
    int         m_own, m_prio, m_cnt;
    logic       m_va, m_vb, m_ga, m_gb;
    logic [7:0] m_rxa, m_rya, m_rxb, m_ryb;
    logic [7:0] m_mem [8] = '{default: 8'h00};

    task automatic model_reset();
        m_own = 0; m_prio = 0; m_cnt = 0;
        m_va = 0; m_vb = 0; m_ga = 0; m_gb = 0;
        m_rxa = 0; m_rya = 0; m_rxb = 0; m_ryb = 0;
    endtask

    task automatic model_gnt(output logic ga, output logic gb);
        if (m_own == 1)      begin ga = ReqA; gb = 1'b0; end
        else if (m_own == 2) begin ga = 1'b0; gb = ReqB; end
        else if (ReqA && ReqB) begin ga = (m_prio == 0); gb = (m_prio == 1); end
        else                 begin ga = ReqA; gb = ReqB; end
    endtask

    task automatic check_model();
        logic ga, gb;
        model_gnt(ga, gb);
        chk("gnt_a", GntA, ga);
        chk("gnt_b", GntB, gb);
        chk("excl",  GntA & GntB, 0);
        chk("rw",    RW, (ga & WrA) | (gb & WrB));
        chk("selr",  SelR, ga ? SelA : (gb ? SelB : 6'd0));
        chk("dw",    DW,   ga ? DatA : (gb ? DatB : 8'd0));
        chk("vld_a", VldA, m_va);
        chk("vld_b", VldB, m_vb);
        chk("rx_a",  RxA, m_rxa);
        chk("ry_a",  RyA, m_rya);
        chk("rx_b",  RxB, m_rxb);
        chk("ry_b",  RyB, m_ryb);
    endtask

    task automatic model_update();
        logic ga, gb, g, lk, orq;
        int s, x;
        model_gnt(ga, gb);
        m_ga = ga; m_gb = gb;
        m_va = ga && !WrA;
        m_vb = gb && !WrB;
        if (m_va) begin m_rxa = m_mem[SelA[2:0]]; m_rya = m_mem[SelA[5:3]]; end
        if (m_vb) begin m_rxb = m_mem[SelB[2:0]]; m_ryb = m_mem[SelB[5:3]]; end
        if (ga && WrA) m_mem[SelA[2:0]] = DatA;
        if (gb && WrB) m_mem[SelB[2:0]] = DatB;
        g   = ga | gb;
        s   = gb ? 1 : 0;
        lk  = gb ? LockB : LockA;
        orq = gb ? ReqA : ReqB;
        if (m_own == 0) begin
            if (g) begin
                if (!lk) m_prio = 1 - s;
                else begin
                    m_cnt = 1;
                    if (m_cnt >= LOCK_MAX && orq) m_prio = 1 - s;
                    else m_own = s + 1;
                end
            end
        end else begin
            x = m_own - 1;
            if (!g || !lk) begin
                m_own = 0; m_prio = 1 - x;
            end else begin
                m_cnt = (m_cnt + 1 > LOCK_MAX) ? LOCK_MAX : m_cnt + 1;
                if (m_cnt == LOCK_MAX && orq) begin m_own = 0; m_prio = 1 - x; end
            end
        end
    endtask

    // Called with inputs already applied just after a falling edge.
    task automatic tick();
        #2 check_model();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic set_in(input logic ra, wa, la, input logic [5:0] sa, input logic [7:0] da,
                          input logic rb, wb, lb, input logic [5:0] sb, input logic [7:0] db);
        ReqA = ra; WrA = wa; LockA = la; SelA = sa; DatA = da;
        ReqB = rb; WrB = wb; LockB = lb; SelB = sb; DatB = db;
    endtask

    typedef struct {
        logic       ra, wa, la; logic [5:0] sa; logic [7:0] da;
        logic       rb, wb, lb; logic [5:0] sb; logic [7:0] db;
        logic       ga, gb, rw, va, vb; logic [7:0] ex, ey;
    } vec_t;

    vec_t tbl [24];

    task automatic fill_tbl();
        //                 A: req wr lk sel    dat     B: req wr lk sel    dat     ga gb rw va vb ex     ey
        tbl[0]  = '{T,T,F,6'o03,8'h5A, F,F,F,6'o00,8'h00, T,F,T,F,F,8'h00,8'h00};
        tbl[1]  = '{T,F,F,6'o33,8'h00, F,F,F,6'o00,8'h00, T,F,F,F,F,8'h00,8'h00};
        tbl[2]  = '{F,F,F,6'o00,8'h00, T,T,F,6'o02,8'h11, F,T,T,T,F,8'h5A,8'h5A};
        tbl[3]  = '{F,F,F,6'o00,8'h00, T,T,F,6'o07,8'hEE, F,T,T,F,F,8'h00,8'h00};
        tbl[4]  = '{T,F,F,6'o00,8'h00, T,F,F,6'o72,8'h00, T,F,F,F,F,8'h00,8'h00};
        tbl[5]  = '{T,F,F,6'o00,8'h00, T,F,F,6'o72,8'h00, F,T,F,T,F,8'h00,8'h00};
        tbl[6]  = '{T,F,F,6'o00,8'h00, T,F,F,6'o72,8'h00, T,F,F,F,T,8'h11,8'hEE};
        tbl[7]  = '{T,F,F,6'o00,8'h00, T,F,F,6'o72,8'h00, F,T,F,T,F,8'h00,8'h00};
        tbl[8]  = '{F,F,F,6'o00,8'h00, F,F,F,6'o00,8'h00, F,F,F,F,T,8'h11,8'hEE};
        tbl[9]  = '{T,F,T,6'o00,8'h00, T,F,F,6'o72,8'h00, T,F,F,F,F,8'h00,8'h00};
        for (int i = 10; i <= 12; i++)
            tbl[i] = '{T,F,T,6'o00,8'h00, T,F,F,6'o72,8'h00, T,F,F,T,F,8'h00,8'h00};
        tbl[13] = '{T,F,T,6'o00,8'h00, T,F,F,6'o72,8'h00, F,T,F,T,F,8'h00,8'h00};
        tbl[14] = '{F,F,F,6'o00,8'h00, F,F,F,6'o00,8'h00, F,F,F,F,T,8'h11,8'hEE};
        tbl[15] = '{T,F,T,6'o00,8'h00, F,F,F,6'o00,8'h00, T,F,F,F,F,8'h00,8'h00};
        for (int i = 16; i <= 20; i++)
            tbl[i] = '{T,F,T,6'o00,8'h00, F,F,F,6'o00,8'h00, T,F,F,T,F,8'h00,8'h00};
        tbl[21] = '{T,F,F,6'o00,8'h00, F,F,F,6'o00,8'h00, T,F,F,T,F,8'h00,8'h00};
        tbl[22] = '{F,F,F,6'o00,8'h00, T,F,F,6'o72,8'h00, F,T,F,T,F,8'h00,8'h00};
        tbl[23] = '{F,F,F,6'o00,8'h00, F,F,F,6'o00,8'h00, F,F,F,F,T,8'h11,8'hEE};
    endtask

    initial begin
        logic a_wait, b_wait;
        fill_tbl();
        model_reset();

        // Reset state, with A already requesting a write.
        Rst = 1'b1;
        set_in(T, T, F, 6'o03, 8'h5A, T, T, F, 6'o01, 8'h33);
        #2;
        chk("rst_gnt_a", GntA, 0);
        chk("rst_gnt_b", GntB, 0);
        chk("rst_rw",    RW,   0);
        chk("rst_selr",  SelR, 0);
        chk("rst_dw",    DW,   0);
        chk("rst_vld",   {VldA, VldB}, 0);
        chk("rst_rx",    {RxA, RyA, RxB, RyB}, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        // Directed vectors.
        foreach (tbl[i]) begin
            set_in(tbl[i].ra, tbl[i].wa, tbl[i].la, tbl[i].sa, tbl[i].da,
                   tbl[i].rb, tbl[i].wb, tbl[i].lb, tbl[i].sb, tbl[i].db);
            #1;
            chk($sformatf("v%0d_gnt_a", i), GntA, tbl[i].ga);
            chk($sformatf("v%0d_gnt_b", i), GntB, tbl[i].gb);
            chk($sformatf("v%0d_rw", i),    RW,   tbl[i].rw);
            chk($sformatf("v%0d_vld_a", i), VldA, tbl[i].va);
            chk($sformatf("v%0d_vld_b", i), VldB, tbl[i].vb);
            if (tbl[i].va) chk($sformatf("v%0d_rxy_a", i), {RxA, RyA}, {tbl[i].ex, tbl[i].ey});
            if (tbl[i].vb) chk($sformatf("v%0d_rxy_b", i), {RxB, RyB}, {tbl[i].ex, tbl[i].ey});
            if (tbl[i].ga) chk($sformatf("v%0d_selr", i), SelR, tbl[i].sa);
            tick();
        end

        // Random traffic; a waiting requester mostly holds, sometimes cancels.
        a_wait = 0; b_wait = 0;
        for (int c = 0; c < 400; c++) begin
            if (a_wait) begin
                if ($urandom_range(7) == 0) ReqA = 1'b0;
            end else begin
                ReqA = ($urandom_range(2) != 0); WrA = ($urandom_range(1) != 0);
                LockA = ($urandom_range(2) == 0); SelA = 6'($urandom); DatA = 8'($urandom);
            end
            if (b_wait) begin
                if ($urandom_range(7) == 0) ReqB = 1'b0;
            end else begin
                ReqB = ($urandom_range(2) != 0); WrB = ($urandom_range(1) != 0);
                LockB = ($urandom_range(2) == 0); SelB = 6'($urandom); DatB = 8'($urandom);
            end
            tick();
            a_wait = ReqA && !m_ga;
            b_wait = ReqB && !m_gb;
        end

        // Reset in the middle of an OWN_B write cycle.
        set_in(F, F, F, 6'o00, 8'h00, F, F, F, 6'o00, 8'h00);
        tick();
        tick();
        set_in(F, F, F, 6'o00, 8'h00, T, T, T, 6'o04, 8'h77);
        tick();
        set_in(F, F, F, 6'o00, 8'h00, T, T, T, 6'o04, 8'hC3);
        #1;
        chk("lk_gnt_b", GntB, 1);
        chk("lk_rw",    RW,   1);
        #1 Rst = 1'b1;
        #1;
        chk("rst_mid_gnt_b", GntB, 0);
        chk("rst_mid_rw",    RW,   0);
        chk("rst_mid_vld_b", VldB, 0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
        set_in(T, F, F, 6'o44, 8'h00, T, F, F, 6'o00, 8'h00);
        #1;
        chk("post_rst_gnt_a", GntA, 1);
        chk("post_rst_gnt_b", GntB, 0);
        tick();
        set_in(F, F, F, 6'o00, 8'h00, F, F, F, 6'o00, 8'h00);
        #1;
        chk("post_rst_vld_a", VldA, 1);
        chk("aborted_write",  RxA, 8'h77);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
